// File: rtl/wishbone_master_bridge.sv
// wishbone_master_bridge
//
// Converts the memory controller's enable/busy request (0x1xxx_xxxx window)
// into one Wishbone classic master cycle per request. It returns read data and
// a one-cycle completion strobe (wbBusy low) to the controller.
//
// Optional feature macro: WB_TIMEOUT_EN. When it is defined, a bus cycle that
// stays unterminated for TIMEOUT_CYCLES cycles is aborted as if wb_err_i had
// been asserted.
//
// Ports
//   clk, rst          system clock, synchronous active-high reset
//   wbAddress[27:0]   request byte address (bits [1:0] ignored)
//   wbByteSelect[3:0] request byte lanes
//   wbEnable          request valid
//   wbWriteEnable     1 = write, 0 = read
//   wbDataWrite[31:0] request write data
//   wbDataRead[31:0]  read data, valid while wbBusy is low
//   wbBusy            low only in the completion cycle
//   wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_adr_o, wb_data_o
//                     registered Wishbone master outputs
//   wb_data_i         slave read data
//   wb_ack_i, wb_err_i slave termination
//   busError          pulse in a completion cycle caused by error or timeout
module wishbone_master_bridge #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [27:0] wbAddress,
    input  logic [3:0]  wbByteSelect,
    input  logic        wbEnable,
    input  logic        wbWriteEnable,
    input  logic [31:0] wbDataWrite,
    output logic [31:0] wbDataRead,
    output logic        wbBusy,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic        wb_we_o,
    output logic [3:0]  wb_sel_o,
    output logic [27:0] wb_adr_o,
    output logic [31:0] wb_data_o,
    input  logic [31:0] wb_data_i,
    input  logic        wb_ack_i,
    input  logic        wb_err_i,
    output logic        busError
);

    // The timeout counter is 8 bits wide, so only 1..255 is meaningful.
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : gBadTimeout
        $error("TIMEOUT_CYCLES must be in 1..255");
    end

    typedef enum logic [1:0] {StIdle, StCycle, StDone} state_t;

    state_t      stateQ, stateD;
    logic        cycQ, cycD;
    logic        stbQ, stbD;
    logic        weQ, weD;
    logic [3:0]  selQ, selD;
    logic [27:0] adrQ, adrD;
    logic [31:0] dataOutQ, dataOutD;
    logic [31:0] readQ, readD;
    logic        busErrQ, busErrD;

`ifdef WB_TIMEOUT_EN
    localparam logic [7:0] TimeoutLimit = 8'(TIMEOUT_CYCLES);
    logic [7:0] cntQ, cntD;
    logic       timeoutHit;
    // cntQ counts completed unterminated cycles; this cycle would be cntQ + 1.
    assign timeoutHit = (cntQ + 8'd1) == TimeoutLimit;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            stateQ   <= StIdle;
            cycQ     <= 1'b0;
            stbQ     <= 1'b0;
            weQ      <= 1'b0;
            selQ     <= 4'h0;
            adrQ     <= 28'h0;
            dataOutQ <= 32'h0;
            readQ    <= 32'hFFFF_FFFF;
            busErrQ  <= 1'b0;
`ifdef WB_TIMEOUT_EN
            cntQ     <= 8'h0;
`endif
        end else begin
            stateQ   <= stateD;
            cycQ     <= cycD;
            stbQ     <= stbD;
            weQ      <= weD;
            selQ     <= selD;
            adrQ     <= adrD;
            dataOutQ <= dataOutD;
            readQ    <= readD;
            busErrQ  <= busErrD;
`ifdef WB_TIMEOUT_EN
            cntQ     <= cntD;
`endif
        end
    end

    always_comb begin
        stateD   = stateQ;
        cycD     = cycQ;
        stbD     = stbQ;
        weD      = weQ;
        selD     = selQ;
        adrD     = adrQ;
        dataOutD = dataOutQ;
        readD    = readQ;
        // busError only ever lives for the single DONE cycle.
        busErrD  = 1'b0;
`ifdef WB_TIMEOUT_EN
        cntD     = cntQ;
`endif

        unique case (stateQ)
            // DONE accepts a new request exactly like IDLE (back-to-back).
            StIdle, StDone: begin
                stateD = StIdle;
                if (wbEnable) begin
                    cycD     = 1'b1;
                    stbD     = 1'b1;
                    weD      = wbWriteEnable;
                    selD     = wbByteSelect;
                    adrD     = wbAddress & ~28'h3;
                    dataOutD = wbDataWrite;
                    stateD   = StCycle;
`ifdef WB_TIMEOUT_EN
                    cntD     = 8'h0;
`endif
                end
            end
            StCycle: begin
                if (wb_err_i) begin
                    cycD    = 1'b0;
                    stbD    = 1'b0;
                    weD     = 1'b0;
                    readD   = 32'hFFFF_FFFF;
                    busErrD = 1'b1;
                    stateD  = StDone;
                end else if (wb_ack_i) begin
                    cycD   = 1'b0;
                    stbD   = 1'b0;
                    weD    = 1'b0;
                    if (!weQ) begin
                        readD = wb_data_i;
                    end
                    stateD = StDone;
                end
`ifdef WB_TIMEOUT_EN
                else if (timeoutHit) begin
                    cycD    = 1'b0;
                    stbD    = 1'b0;
                    weD     = 1'b0;
                    readD   = 32'hFFFF_FFFF;
                    busErrD = 1'b1;
                    stateD  = StDone;
                end else begin
                    cntD = cntQ + 8'd1;
                end
`endif
            end
            default: stateD = StIdle;
        endcase
    end

    // Controller-facing outputs come straight from registers.
    assign wbBusy     = (stateQ != StDone);
    assign wbDataRead = readQ;
    assign busError   = busErrQ;
    assign wb_cyc_o   = cycQ;
    assign wb_stb_o   = stbQ;
    assign wb_we_o    = weQ;
    assign wb_sel_o   = selQ;
    assign wb_adr_o   = adrQ;
    assign wb_data_o  = dataOutQ;

endmodule
